// File: rtl/spi_pkg.sv
// Shared types for the SPI transaction sequencer slice.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO,
        CAPTURE
    } seq_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock valid/ready FIFO with synchronous active-low reset.
// A pop frees its slot for a push in the same cycle, even when full.
module spi_sync_fifo #(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_wr_valid,
    output logic         o_wr_ready,
    output logic [W-1:0] o_rd_data,
    output logic         o_rd_valid,
    input  logic         i_rd_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);
    assign pop   = i_rd_ready && !empty;
    assign push  = i_wr_valid && (!full || pop);

    assign o_wr_ready = !full;
    assign o_rd_valid = !empty;
    assign o_rd_data  = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

endmodule

// File: rtl/spi_txn_sequencer.sv
// Feeds host TX words to the SPI master one transfer at a time and
// collects the received words into an RX FIFO for the host.
module spi_txn_sequencer
    import spi_pkg::*;
#(
    parameter int BITS    = 5,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [BITS-1:0] i_wr_data,
    input  logic            i_wr_valid,
    output logic            o_wr_ready,
    output logic [BITS-1:0] o_rd_data,
    output logic            o_rd_valid,
    input  logic            i_rd_ready,
    output logic            o_send,
    output logic [BITS-1:0] o_data,
    input  logic            i_busy,
    input  logic [BITS-1:0] i_data,
    input  logic            i_clr,
    output logic            o_rx_ovf,
    output logic            o_timeout,
    output logic            o_active
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_nxt;
    logic [BITS-1:0] data_q;
    logic [BITS-1:0] data_nxt;
    logic            rx_ovf_q;
    logic            timeout_q;
    logic            set_ovf;
    logic            set_timeout;

    logic [BITS-1:0] tx_rd_data;
    logic            tx_rd_valid;
    logic            tx_wr_ready;
    logic            tx_pop;
    logic            rx_push;
    logic            rx_wr_ready;

    // The host push is gated by ready so a word offered while full is never taken.
    spi_sync_fifo #(.W(BITS), .DEPTH(DEPTH)) u_tx_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_data  (i_wr_data),
        .i_wr_valid (i_wr_valid && tx_wr_ready),
        .o_wr_ready (tx_wr_ready),
        .o_rd_data  (tx_rd_data),
        .o_rd_valid (tx_rd_valid),
        .i_rd_ready (tx_pop)
    );

    spi_sync_fifo #(.W(BITS), .DEPTH(DEPTH)) u_rx_fifo (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wr_data  (i_data),
        .i_wr_valid (rx_push),
        .o_wr_ready (rx_wr_ready),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .i_rd_ready (i_rd_ready)
    );

    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        data_nxt    = data_q;
        tx_pop      = 1'b0;
        o_send      = 1'b0;
        rx_push     = 1'b0;
        set_ovf     = 1'b0;
        set_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (tx_rd_valid) begin
                    tx_pop    = 1'b1;
                    data_nxt  = tx_rd_data;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                o_send    = !i_busy;
                timer_nxt = '0;
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (i_busy) begin
                    state_nxt = WAIT_LO;
                end else if (timer == TIMER_LAST) begin
                    set_timeout = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!i_busy) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                // A full RX FIFO still accepts the word if the host pops this cycle.
                rx_push   = 1'b1;
                set_ovf   = !rx_wr_ready && !i_rd_ready;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state     <= IDLE;
            timer     <= '0;
            data_q    <= '0;
            rx_ovf_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            data_q    <= data_nxt;
            rx_ovf_q  <= set_ovf || (rx_ovf_q && !i_clr);
            timeout_q <= set_timeout || (timeout_q && !i_clr);
        end
    end

    assign o_wr_ready = tx_wr_ready;
    assign o_data     = data_q;
    assign o_rx_ovf   = rx_ovf_q;
    assign o_timeout  = timeout_q;
    assign o_active   = (state != IDLE);

endmodule
